// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared bus layouts, field offsets and FSM states for wb_stage
// Lane buses and forward buses are described as packed structs so both views stay in sync.
package wb_stage_pkg;

  localparam int ES_TO_WS_BUS_WD = 117;
  localparam int FORWAED_BUS_WD  = 86;

  localparam int FWD_VALID        = 85;
  localparam int FWD_CSR_WEN      = 84;
  localparam int FWD_CSR_ADDR_MSB = 83;
  localparam int FWD_CSR_ADDR_LSB = 70;
  localparam int FWD_CSR_DATA_MSB = 69;
  localparam int FWD_CSR_DATA_LSB = 38;
  localparam int FWD_GR_WE        = 37;
  localparam int FWD_DEST_MSB     = 36;
  localparam int FWD_DEST_LSB     = 32;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_CSR_SPLIT = 1'b1
  } ws_state_t;

  // Field order matches the EXM bus, MSB first.
  typedef struct packed {
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        valid;
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_bus_t;

  function automatic logic [FORWAED_BUS_WD-1:0] pack_fwd(input logic valid, input es_bus_t b);
    fwd_bus_t f;
    f.valid     = valid;
    f.csr_wen   = b.csr_wen;
    f.csr_addr  = b.csr_addr;
    f.csr_wdata = b.csr_wdata;
    f.gr_we     = b.gr_we;
    f.dest      = b.dest;
    f.result    = b.result;
    return f;
  endfunction

endpackage

// File: rtl/wb_lane_unpack.sv
// rtl/wb_lane_unpack.sv - splits one EXM lane bus, derives commit, packs the forward bus
module wb_lane_unpack
  import wb_stage_pkg::*;
(
  input  logic [1:0]                 valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] bus,
  output logic                       commit,
  output es_bus_t                    fields,
  output logic [FORWAED_BUS_WD-1:0]  fwd
);

  assign fields = es_bus_t'(bus);
  // An instruction retires only once both halves of its pair have completed.
  assign commit = valid[0] & valid[1];
  assign fwd    = pack_fwd(commit, fields);

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - dual-lane write-back stage with serialised dual CSR writes
// Optional trace outputs are enabled by defining WB_TRACE_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_ready,
  input  logic [1:0]                 es0_to_ws_valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] es0_to_ws_bus,
  input  logic [1:0]                 es1_to_ws_valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] es1_to_ws_bus,
  output logic                       rf_we0,
  output logic [4:0]                 rf_waddr0,
  output logic [31:0]                rf_wdata0,
  output logic                       rf_we1,
  output logic [4:0]                 rf_waddr1,
  output logic [31:0]                rf_wdata1,
  output logic                       csr_we,
  output logic [13:0]                csr_waddr,
  output logic [31:0]                csr_wdata,
  output logic [FORWAED_BUS_WD-1:0]  forward_data1,
  output logic [FORWAED_BUS_WD-1:0]  forward_data2,
`ifdef WB_TRACE_EN
  output logic [31:0]                debug0_pc,
  output logic [3:0]                 debug0_rf_we,
  output logic [4:0]                 debug0_wnum,
  output logic [31:0]                debug0_wdata,
  output logic [31:0]                debug1_pc,
  output logic [3:0]                 debug1_rf_we,
  output logic [4:0]                 debug1_wnum,
  output logic [31:0]                debug1_wdata,
`endif
  output logic [INSTRET_W-1:0]       instret
);

  es_bus_t   l0, l1;
  logic      commit0, commit1;
  ws_state_t state, next_state;

  logic      split_req;
  logic      gpr_en;
  logic      csr_we_c;
  logic      csr_sel1;
  logic      we0_raw, we1_raw;
  logic [1:0] retire_cnt;

  wb_lane_unpack u_lane0 (
    .valid  (es0_to_ws_valid),
    .bus    (es0_to_ws_bus),
    .commit (commit0),
    .fields (l0),
    .fwd    (forward_data1)
  );

  wb_lane_unpack u_lane1 (
    .valid  (es1_to_ws_valid),
    .bus    (es1_to_ws_bus),
    .commit (commit1),
    .fields (l1),
    .fwd    (forward_data2)
  );

  assign split_req = commit0 & commit1 & l0.csr_wen & l1.csr_wen;

  // Lane 1 is younger, so it owns a same-destination conflict.
  assign we1_raw = commit1 & l1.gr_we & (l1.dest != 5'd0);
  assign we0_raw = commit0 & l0.gr_we & (l0.dest != 5'd0) &
                   !(commit1 & l1.gr_we & (l1.dest == l0.dest));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ws_ready   = 1'b1;
    gpr_en     = 1'b0;
    csr_we_c   = 1'b0;
    csr_sel1   = 1'b0;
    case (state)
      S_IDLE: begin
        gpr_en = 1'b1;
        if (split_req) begin
          ws_ready   = 1'b0;
          next_state = S_CSR_SPLIT;
          csr_we_c   = 1'b1;
          csr_sel1   = 1'b0;
        end else begin
          csr_we_c = (commit0 & l0.csr_wen) | (commit1 & l1.csr_wen);
          csr_sel1 = !(commit0 & l0.csr_wen);
        end
      end
      S_CSR_SPLIT: begin
        // EXM holds the pair while ws_ready was low; only lane 1's CSR write remains.
        next_state = S_IDLE;
        csr_we_c   = commit1 & l1.csr_wen;
        csr_sel1   = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign rf_we0    = !reset & gpr_en & we0_raw;
  assign rf_waddr0 = reset ? 5'd0  : l0.dest;
  assign rf_wdata0 = reset ? 32'd0 : l0.result;
  assign rf_we1    = !reset & gpr_en & we1_raw;
  assign rf_waddr1 = reset ? 5'd0  : l1.dest;
  assign rf_wdata1 = reset ? 32'd0 : l1.result;

  assign csr_we    = !reset & csr_we_c;
  assign csr_waddr = reset ? 14'd0 : (csr_sel1 ? l1.csr_addr  : l0.csr_addr);
  assign csr_wdata = reset ? 32'd0 : (csr_sel1 ? l1.csr_wdata : l0.csr_wdata);

  assign retire_cnt = {1'b0, commit0} + {1'b0, commit1};

  // A split pair is counted only when it finally leaves the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         instret <= '0;
    else if (ws_ready) instret <= instret + {{(INSTRET_W-2){1'b0}}, retire_cnt};
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug0_pc    <= 32'd0;
      debug0_rf_we <= 4'd0;
      debug0_wnum  <= 5'd0;
      debug0_wdata <= 32'd0;
      debug1_pc    <= 32'd0;
      debug1_rf_we <= 4'd0;
      debug1_wnum  <= 5'd0;
      debug1_wdata <= 32'd0;
    end else begin
      debug0_pc    <= l0.pc;
      debug0_rf_we <= {4{rf_we0}};
      debug0_wnum  <= rf_waddr0;
      debug0_wdata <= rf_wdata0;
      debug1_pc    <= l1.pc;
      debug1_rf_we <= {4{rf_we1}};
      debug1_wnum  <= rf_waddr1;
      debug1_wdata <= rf_wdata1;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{l0.pc, l1.pc};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (trace checks when WB_TRACE_EN is defined)
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_ready;
  logic [1:0]   es0_to_ws_valid, es1_to_ws_valid;
  logic [116:0] es0_to_ws_bus, es1_to_ws_bus;
  logic         rf_we0, rf_we1, csr_we;
  logic [4:0]   rf_waddr0, rf_waddr1;
  logic [31:0]  rf_wdata0, rf_wdata1, csr_wdata;
  logic [13:0]  csr_waddr;
  logic [85:0]  forward_data1, forward_data2;
  logic [63:0]  instret;
`ifdef WB_TRACE_EN
  logic [31:0]  debug0_pc, debug0_wdata, debug1_pc, debug1_wdata;
  logic [3:0]   debug0_rf_we, debug1_rf_we;
  logic [4:0]   debug0_wnum, debug1_wnum;
`endif

  wb_stage #(.INSTRET_W(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .ws_ready        (ws_ready),
    .es0_to_ws_valid (es0_to_ws_valid),
    .es0_to_ws_bus   (es0_to_ws_bus),
    .es1_to_ws_valid (es1_to_ws_valid),
    .es1_to_ws_bus   (es1_to_ws_bus),
    .rf_we0          (rf_we0),
    .rf_waddr0       (rf_waddr0),
    .rf_wdata0       (rf_wdata0),
    .rf_we1          (rf_we1),
    .rf_waddr1       (rf_waddr1),
    .rf_wdata1       (rf_wdata1),
    .csr_we          (csr_we),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .forward_data1   (forward_data1),
    .forward_data2   (forward_data2),
`ifdef WB_TRACE_EN
    .debug0_pc       (debug0_pc),
    .debug0_rf_we    (debug0_rf_we),
    .debug0_wnum     (debug0_wnum),
    .debug0_wdata    (debug0_wdata),
    .debug1_pc       (debug1_pc),
    .debug1_rf_we    (debug1_rf_we),
    .debug1_wnum     (debug1_wnum),
    .debug1_wdata    (debug1_wdata),
`endif
    .instret         (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ws;
    logic        we0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        cwe;
    logic [13:0] ca;
    logic [31:0] cd;
    logic        fv1;
    logic        fv2;
    logic [63:0] ins;
    logic [3:0]  dwe0;
    logic [3:0]  dwe1;
    logic [31:0] dpc1;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_ins = 64'd0;
  logic [3:0]  prev_we0 = 4'd0, prev_we1 = 4'd0;
  logic [31:0] prev_pc1 = 32'd0;

  function automatic logic [116:0] mkbus(input logic cw, input logic [13:0] ca, input logic [31:0] cd,
                                         input logic gw, input logic [4:0] d, input logic [31:0] r,
                                         input logic [31:0] pc);
    return {cw, ca, cd, gw, d, r, pc};
  endfunction

  function automatic exp_t mkexp(input logic ws, input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic cwe, input logic [13:0] ca, input logic [31:0] cd,
                                 input logic fv1, input logic fv2);
    exp_t e;
    e = '0;
    e.ws = ws; e.we0 = we0; e.a0 = a0; e.d0 = d0;
    e.we1 = we1; e.a1 = a1; e.d1 = d1;
    e.cwe = cwe; e.ca = ca; e.cd = cd; e.fv1 = fv1; e.fv2 = fv2;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input logic rst_v, input logic [1:0] v0, input logic [116:0] b0,
                      input logic [1:0] v1, input logic [116:0] b1, input exp_t e_in);
    exp_t e;
    e = e_in;
    @(posedge clk);
    #1;
    reset = rst_v;
    es0_to_ws_valid = v0; es0_to_ws_bus = b0;
    es1_to_ws_valid = v1; es1_to_ws_bus = b1;
    if (rst_v) begin
      model_ins = 64'd0;
      prev_we0 = 4'd0; prev_we1 = 4'd0; prev_pc1 = 32'd0;
    end
    e.ins  = model_ins;
    e.dwe0 = prev_we0;
    e.dwe1 = prev_we1;
    e.dpc1 = prev_pc1;
    sb.push_back(e);
    if (!rst_v) begin
      if (e.ws) model_ins = model_ins + 64'(v0 == 2'b11) + 64'(v1 == 2'b11);
      prev_we0 = {4{e.we0}};
      prev_we1 = {4{e.we1}};
      prev_pc1 = b1[31:0];
    end
  endtask

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ws_ready", 64'(ws_ready), 64'(e.ws));
        chk("rf_we0", 64'(rf_we0), 64'(e.we0));
        chk("rf_we1", 64'(rf_we1), 64'(e.we1));
        chk("csr_we", 64'(csr_we), 64'(e.cwe));
        chk("fwd1_valid", 64'(forward_data1[85]), 64'(e.fv1));
        chk("fwd2_valid", 64'(forward_data2[85]), 64'(e.fv2));
        chk("instret", instret, e.ins);
        if (e.we0) begin
          chk("rf_waddr0", 64'(rf_waddr0), 64'(e.a0));
          chk("rf_wdata0", 64'(rf_wdata0), 64'(e.d0));
        end
        if (e.we1) begin
          chk("rf_waddr1", 64'(rf_waddr1), 64'(e.a1));
          chk("rf_wdata1", 64'(rf_wdata1), 64'(e.d1));
        end
        if (e.cwe) begin
          chk("csr_waddr", 64'(csr_waddr), 64'(e.ca));
          chk("csr_wdata", 64'(csr_wdata), 64'(e.cd));
        end
`ifdef WB_TRACE_EN
        chk("debug0_rf_we", 64'(debug0_rf_we), 64'(e.dwe0));
        chk("debug1_rf_we", 64'(debug1_rf_we), 64'(e.dwe1));
        chk("debug1_pc", 64'(debug1_pc), 64'(e.dpc1));
`endif
      end
    end
  end

  localparam logic [116:0] Z = '0;

  initial begin
    int budget;
    reset = 1'b1;
    es0_to_ws_valid = 2'b00; es0_to_ws_bus = '0;
    es1_to_ws_valid = 2'b00; es1_to_ws_bus = '0;

    // reset state
    step(1, 2'b00, Z, 2'b00, Z, mkexp(1, 0,0,0, 0,0,0, 0,0,0, 0,0));
    // single lane0 commit
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd5,32'h1234,32'h1c000000), 2'b00, Z,
         mkexp(1, 1,5'd5,32'h1234, 0,0,0, 0,0,0, 1,0));
    // same destination: lane1 wins
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd7,32'hA,32'h1c000000), 2'b11, mkbus(0,14'h0,32'h0,1,5'd7,32'hB,32'h1c000004),
         mkexp(1, 0,0,0, 1,5'd7,32'hB, 0,0,0, 1,1));
    // distinct destinations both write
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd3,32'h33,32'h1c000008), 2'b11, mkbus(0,14'h0,32'h0,1,5'd4,32'h44,32'h1c00000c),
         mkexp(1, 1,5'd3,32'h33, 1,5'd4,32'h44, 0,0,0, 1,1));
    // dual CSR split: first cycle lane0 CSR + GPR writes, stall
    step(0, 2'b11, mkbus(1,14'h0,32'h1,1,5'd8,32'h80,32'h1c000010), 2'b11, mkbus(1,14'h6,32'h2,1,5'd9,32'h90,32'h1c000014),
         mkexp(0, 1,5'd8,32'h80, 1,5'd9,32'h90, 1,14'h0,32'h1, 1,1));
    // second cycle: lane1 CSR only
    step(0, 2'b11, mkbus(1,14'h0,32'h1,1,5'd8,32'h80,32'h1c000010), 2'b11, mkbus(1,14'h6,32'h2,1,5'd9,32'h90,32'h1c000014),
         mkexp(1, 0,0,0, 0,0,0, 1,14'h6,32'h2, 1,1));
    // x0 suppressed; incomplete pair on lane1 does nothing
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd0,32'h77,32'h1c000018), 2'b01, mkbus(0,14'h0,32'h0,1,5'd3,32'h99,32'h1c00001c),
         mkexp(1, 0,0,0, 0,0,0, 0,0,0, 1,0));
    // single CSR on lane1 plus GPR writes on both lanes
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd10,32'hAA,32'h1c00000c), 2'b11, mkbus(1,14'h300,32'hdead,1,5'd2,32'h55,32'h1c000010),
         mkexp(1, 1,5'd10,32'hAA, 1,5'd2,32'h55, 1,14'h300,32'hdead, 1,1));
    // idle
    step(0, 2'b00, Z, 2'b00, Z, mkexp(1, 0,0,0, 0,0,0, 0,0,0, 0,0));
    // split pair, then reset while in CSR_SPLIT
    step(0, 2'b11, mkbus(1,14'h11,32'h5,0,5'd0,32'h0,32'h1c000020), 2'b11, mkbus(1,14'h22,32'h6,0,5'd0,32'h0,32'h1c000024),
         mkexp(0, 0,0,0, 0,0,0, 1,14'h11,32'h5, 1,1));
    step(1, 2'b11, mkbus(1,14'h11,32'h5,0,5'd0,32'h0,32'h1c000020), 2'b11, mkbus(1,14'h22,32'h6,0,5'd0,32'h0,32'h1c000024),
         mkexp(0, 0,0,0, 0,0,0, 0,0,0, 1,1));
    step(0, 2'b00, Z, 2'b00, Z, mkexp(1, 0,0,0, 0,0,0, 0,0,0, 0,0));
    // counter restarts from zero
    step(0, 2'b11, mkbus(0,14'h0,32'h0,1,5'd1,32'h1,32'h1c000028), 2'b00, Z,
         mkexp(1, 1,5'd1,32'h1, 0,0,0, 0,0,0, 1,0));
    step(0, 2'b00, Z, 2'b00, Z, mkexp(1, 0,0,0, 0,0,0, 0,0,0, 0,0));

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Dual-lane write-back stage sitting directly downstream of the two EXM_stage lanes; consumes their registered es_to_ws buses and commits results to the regfile and CSR file.
- Lane 0 is older than lane 1; commit is in program order.
- Drives the forward buses consumed by EXM, and the ws_ready back-pressure.
- Serialises dual CSR writes through a two-state FSM and maintains a retired-instruction counter.

Parameters:
INSTRET_W, 64, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ws_ready  out  1  stage can accept new EXM outputs (to both lanes' ws_ready)
es0_to_ws_valid  in  2  lane0: [0] instr valid, [1] pair completed
es0_to_ws_bus  in  `ES_TO_WS_BUS_WD (117)  lane0 {csr_wen, csr_addr[13:0], csr_wdata[31:0], gr_we, dest[4:0], result[31:0], pc[31:0]}
es1_to_ws_valid  in  2  lane1, same encoding
es1_to_ws_bus  in  117  lane1, same format
rf_we0 / rf_waddr0 / rf_wdata0  out  1/5/32  regfile write port 0 (lane0)
rf_we1 / rf_waddr1 / rf_wdata1  out  1/5/32  regfile write port 1 (lane1)
csr_we / csr_waddr / csr_wdata  out  1/14/32  single CSR write port
forward_data1  out  `FORWAED_BUS_WD (86)  lane0 forward {valid, csr_wen, csr_addr, csr_wdata, gr_we, dest, result}
forward_data2  out  86  lane1 forward, same format; has priority in EXM
instret  out  INSTRET_W  retired instruction count

Behaviour:
- Lane commit: commitN = esN_to_ws_valid[0] & esN_to_ws_valid[1].
- States: IDLE, CSR_SPLIT. Reset (async) -> IDLE, instret=0.
- split_req = commit0 & commit1 & csr_wen0 & csr_wen1.
- ws_ready = !(state==IDLE & split_req); combinational.
- IDLE, no split_req:
  - rf_we0 = commit0 & gr_we0 & (dest0!=0) & !(commit1 & gr_we1 & dest1==dest0). Lane1 wins a same-dest conflict.
  - rf_we1 = commit1 & gr_we1 & (dest1!=0).
  - CSR port takes whichever lane has csr_wen (at most one).
- IDLE, split_req:
  - GPR writes as above; CSR port writes lane0 only.
  - ws_ready=0; next state CSR_SPLIT.
- CSR_SPLIT:
  - rf_we0 = rf_we1 = 0; CSR port writes lane1; ws_ready=1; next state IDLE.
  - Inputs are held by EXM because ws_ready was 0.
- Reset during CSR_SPLIT: lane1 CSR write is dropped; FSM returns to IDLE.
- x0 never written; dest==0 forces rf_we low.
- Forward buses: valid bit = commitN; remaining fields copied straight from the lane bus (gr_we, dest, result, csr fields). Driven in both states so EXM forwarding stays stable during the stall.
- instret: on each cycle with ws_ready=1, add (commit0 + commit1) (0, 1 or 2).
  - A split pair adds 2 only in the CSR_SPLIT cycle.
  - Wraps modulo 2^INSTRET_W.
- All regfile/CSR outputs are 0 while reset is asserted.
- Latency: commit is the same cycle as input presentation (0 cycles); split pair takes 2 cycles.

Optional Feature:
WB_TRACE_EN
- Defined: adds outputs debug0_pc/debug1_pc (32), debug0_rf_we/debug1_rf_we (4, replicated), debug0_wnum/debug1_wnum (5), debug0_wdata/debug1_wdata (32).
- Trace outputs are registered one cycle after the GPR write they reflect, and are reset to 0.
- A split pair emits trace in its first cycle only.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- define.vh: ES_TO_WS_BUS_WD, FORWAED_BUS_WD, field bit offsets (FWD_VALID=85, FWD_CSR_WEN=84, FWD_CSR_ADDR=83:70, FWD_CSR_DATA=69:38, FWD_GR_WE=37, FWD_DEST=36:32), FSM state localparams.
- One sub-module, wb_lane_unpack: splits a lane bus, computes commit, and packs the forward bus. Instantiated twice.

Test Plan:
1. Single lane0 commit: gr_we=1, dest=5, result=0x1234 -> rf_we0=1, waddr0=5, wdata0=0x1234; forward_data1[85]=1; instret +1; ws_ready=1.
2. Both lanes dest=7 (0xA, 0xB) -> rf_we0=0, rf_we1=1 with 0xB; instret +2.
3. Both lanes csr_wen (addr 0x0 data 0x1, addr 0x6 data 0x2):
   - Cycle 1: ws_ready=0, csr writes 0x0 <- 0x1.
   - Cycle 2: csr writes 0x6 <- 0x2, ws_ready=1.
   - instret +2 in cycle 2 only.
4. dest=0 with gr_we=1 -> rf_we low; valid[1]=0 with valid[0]=1 -> no writes, forward valid=0.
5. Assert reset in CSR_SPLIT -> outputs 0 immediately, instret=0, next cycle ws_ready=1 in IDLE.
6. WB_TRACE_EN: lane1 commit pc=0x1c000010 -> debug1_pc=0x1c000010, debug1_rf_we=4'hf one cycle later.
